// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FSM sequencing decode, ALU, data memory and PC updates,
// with a sticky trap on illegal opcodes and data-memory timeouts.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        Mem_Rdy,
  output logic        Instr_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_Bsel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_Req,
  output logic        Mem_WrEn,
  output logic        ByteOp,
  output logic        Error
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, ERROR
  } state_t;
  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_SB   = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [7:0] TO      = 8'(MEM_TIMEOUT);
  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [3:0]  func_q, func_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_r, is_i, is_ld, is_st, is_br;
  logic        unused_bits;
  assign unused_bits = ^Instr[25:4];
  assign is_r  = op_q == OP_R;
  assign is_i  = op_q == OP_ADDI || op_q == OP_LI || op_q == OP_LUI || op_q == OP_ANDI || op_q == OP_ORI;
  assign is_ld = op_q == OP_LW || op_q == OP_LB;
  assign is_st = op_q == OP_SW || op_q == OP_SB;
  assign is_br = op_q == OP_B || op_q == OP_BEQ || op_q == OP_BNE;
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    func_d        = func_q;
    cnt_d         = cnt_q;
    Instr_LdEn    = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_Bsel       = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Error         = 1'b0;
    case (state_q)
      FETCH: begin
        Instr_LdEn = 1'b1;
        op_d       = Instr[31:26];
        func_d     = Instr[3:0];
        state_d    = DECODE;
      end
      DECODE: begin
        RF_Bsel = is_st | is_br;
        state_d = is_r ? EXEC_R : is_i ? EXEC_I : (is_ld | is_st) ? MEM_ADDR : is_br ? BRANCH : ERROR;
      end
      EXEC_R: begin
        ALU_func = func_q;
        state_d  = WB_ALU;
      end
      EXEC_I: begin
        ALU_Bin_sel = 1'b1;
        ALU_func    = op_q == OP_ANDI ? 4'b0010 : op_q == OP_ORI ? 4'b0011 : 4'b0000;
        state_d     = WB_ALU;
      end
      WB_ALU: begin
        RF_WrEn = 1'b1;
        PC_LdEn = 1'b1;
        state_d = FETCH;
      end
      MEM_ADDR: begin
        ALU_Bin_sel = 1'b1;
        cnt_d       = 8'd0;
        state_d     = is_ld ? MEM_RD : MEM_WR;
      end
      MEM_RD, MEM_WR: begin
        Mem_Req  = 1'b1;
        Mem_WrEn = state_q == MEM_WR;
        RF_Bsel  = state_q == MEM_WR;
        ByteOp   = op_q == OP_LB || op_q == OP_SB;
        PC_LdEn  = state_q == MEM_WR && Mem_Rdy;
        cnt_d    = Mem_Rdy ? cnt_q : cnt_q + 8'd1;
        // a ready arriving on the limit cycle still completes the access
        state_d  = Mem_Rdy ? (state_q == MEM_WR ? FETCH : WB_MEM) :
                   (cnt_q + 8'd1 == TO) ? ERROR : state_q;
      end
      WB_MEM: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b1;
        PC_LdEn       = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        RF_Bsel  = 1'b1;
        ALU_func = 4'b0001;
        PC_LdEn  = 1'b1;
        PC_sel   = op_q == OP_B || (op_q == OP_BEQ && ALU_zero) || (op_q == OP_BNE && !ALU_zero);
        state_d  = FETCH;
      end
      ERROR: Error = 1'b1;
      default: state_d = ERROR;
    endcase
    // reset aborts the current instruction in the same cycle, so no write can escape
    if (Reset) begin
      {Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_Bsel, ALU_Bin_sel} = '0;
      {ALU_func, Mem_Req, Mem_WrEn, ByteOp, Error} = '0;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= FETCH;
      op_q    <= 6'd0;
      func_q  <= 4'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
